// File: rtl/wb_retire_stage.sv
// wb_retire_stage: LoongArch writeback/retire stage with exception prioritisation and a debug-trace FIFO
// that back-pressures retirement when full.
module wb_retire_stage #(
    parameter int DATA_W      = 32,
    parameter int RF_AW       = 5,
    parameter int CSR_NUM_W   = 14,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ms_valid,
    output logic                 WB_allowin,
    input  logic [DATA_W-1:0]    ms_pc,
    input  logic                 ms_gr_we,
    input  logic [RF_AW-1:0]     ms_rd,
    input  logic [DATA_W-1:0]    ms_result,
    input  logic                 ms_csr_re,
    input  logic [CSR_NUM_W-1:0] ms_csr_num,
    input  logic [5:0]           ms_except,
    input  logic                 ms_ertn,
    input  logic [DATA_W-1:0]    ms_vaddr,
    output logic                 csr_re,
    output logic [CSR_NUM_W-1:0] csr_num,
    input  logic [DATA_W-1:0]    csr_rvalue,
    output logic                 rf_wen,
    output logic [RF_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [DATA_W-1:0]    wb_pc,
    output logic [DATA_W-1:0]    wb_vaddr,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [DATA_W-1:0]    trace_pc,
    output logic [3:0]           trace_wen,
    output logic [RF_AW-1:0]     trace_rd,
    output logic [DATA_W-1:0]    trace_wdata
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(TRACE_DEPTH);

    logic                 wb_valid, gr_we_r, csr_re_r, ertn_r;
    logic [DATA_W-1:0]    pc_r, result_r, vaddr_r;
    logic [RF_AW-1:0]     rd_r;
    logic [CSR_NUM_W-1:0] csr_num_r;
    logic [5:0]           except_r;
    logic                 has_ex, full, retire, push, pop;
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [PW:0]          count;
    logic [DATA_W-1:0]    tq_pc   [TRACE_DEPTH];
    logic                 tq_wen  [TRACE_DEPTH];
    logic [RF_AW-1:0]     tq_rd   [TRACE_DEPTH];
    logic [DATA_W-1:0]    tq_data [TRACE_DEPTH];

    // except_r = {int, adef, ine, sys, brk, ale}, highest priority first
    always_comb begin
        has_ex      = wb_valid & |except_r;
        full        = count == FULL_CNT;
        trace_valid = count != '0;
        retire      = wb_valid & (has_ex | ertn_r | ~full | trace_ready);
        wb_ex       = retire & has_ex;
        ertn_flush  = retire & ertn_r & ~has_ex;
        WB_allowin  = (~wb_valid | retire) & ~wb_ex & ~ertn_flush;
        csr_re      = wb_valid & csr_re_r;
        csr_num     = wb_valid ? csr_num_r : '0;
        rf_wen      = retire & gr_we_r & ~has_ex;
        rf_waddr    = wb_valid ? rd_r : '0;
        rf_wdata    = csr_re ? csr_rvalue : result_r;
        wb_pc       = wb_valid ? pc_r : '0;
        wb_vaddr    = wb_valid ? vaddr_r : '0;
        wb_esubcode = '0;
        wb_ecode    = ~has_ex     ? 6'h00 :
                      except_r[5] ? 6'h00 :
                      except_r[4] ? 6'h08 :
                      except_r[3] ? 6'h0D :
                      except_r[2] ? 6'h0B :
                      except_r[1] ? 6'h0C :
                      except_r[0] ? 6'h09 : 6'h00;
        push        = retire & ~has_ex & ~ertn_r;
        pop         = trace_valid & trace_ready;
        trace_pc    = trace_valid ? tq_pc[rd_ptr] : '0;
        trace_wen   = {4{trace_valid & tq_wen[rd_ptr]}};
        trace_rd    = trace_valid ? tq_rd[rd_ptr] : '0;
        trace_wdata = trace_valid ? tq_data[rd_ptr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            pc_r      <= '0;
            gr_we_r   <= 1'b0;
            rd_r      <= '0;
            result_r  <= '0;
            csr_re_r  <= 1'b0;
            csr_num_r <= '0;
            except_r  <= '0;
            ertn_r    <= 1'b0;
            vaddr_r   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (ms_valid & WB_allowin) begin
                wb_valid  <= 1'b1;
                pc_r      <= ms_pc;
                gr_we_r   <= ms_gr_we;
                rd_r      <= ms_rd;
                result_r  <= ms_result;
                csr_re_r  <= ms_csr_re;
                csr_num_r <= ms_csr_num;
                except_r  <= ms_except;
                ertn_r    <= ms_ertn;
                vaddr_r   <= ms_vaddr;
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset: reads are masked by trace_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tq_pc[wr_ptr]   <= wb_pc;
            tq_wen[wr_ptr]  <= rf_wen;
            tq_rd[wr_ptr]   <= rd_r;
            tq_data[wr_ptr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_wb_retire_stage.sv
// tb_wb_retire_stage: directed stimulus, per-cycle reference-model comparison and literal spot checks.
module tb_wb_retire_stage;
    localparam int TD = 4;
    localparam logic [5:0] EX_INT = 6'b100000, EX_SYS = 6'b000100, EX_BRK = 6'b000010, EX_ALE = 6'b000001;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ms_valid, WB_allowin, ms_gr_we, ms_csr_re, ms_ertn;
    logic [31:0] ms_pc, ms_result, ms_vaddr, csr_rvalue, rf_wdata, wb_pc, wb_vaddr, trace_pc, trace_wdata;
    logic [4:0]  ms_rd, rf_waddr, trace_rd;
    logic [13:0] ms_csr_num, csr_num;
    logic [5:0]  ms_except, wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [3:0]  trace_wen;
    logic        csr_re, rf_wen, wb_ex, ertn_flush, trace_valid, trace_ready;

    always #5 clk = ~clk;

    wb_retire_stage #(.DATA_W(32), .RF_AW(5), .CSR_NUM_W(14), .TRACE_DEPTH(TD)) dut (
        .clk(clk), .rst(rst), .ms_valid(ms_valid), .WB_allowin(WB_allowin), .ms_pc(ms_pc),
        .ms_gr_we(ms_gr_we), .ms_rd(ms_rd), .ms_result(ms_result), .ms_csr_re(ms_csr_re),
        .ms_csr_num(ms_csr_num), .ms_except(ms_except), .ms_ertn(ms_ertn), .ms_vaddr(ms_vaddr),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_wen(trace_wen), .trace_rd(trace_rd), .trace_wdata(trace_wdata)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [5:0]  exc;
        logic        ertn;
        logic [31:0] vaddr;
    } ins_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } tr_t;

    function automatic logic [5:0] ecode_of(input logic [5:0] e);
        if (e[5]) return 6'h00;
        if (e[4]) return 6'h08;
        if (e[3]) return 6'h0D;
        if (e[2]) return 6'h0B;
        if (e[1]) return 6'h0C;
        if (e[0]) return 6'h09;
        return 6'h00;
    endfunction

    // Reference model: one held instruction plus a queue of committed trace entries.
    bit   m_valid = 0;
    ins_t m_ins = '0;
    tr_t  tq[$];

    always @(negedge clk) begin
        bit hx, rt, wen, ex, er, al, tv;
        logic [31:0] wd;
        tr_t head, e;
        if (rst) begin
            m_valid = 0;
            tq.delete();
        end
        hx = m_valid && m_ins.exc != 0;
        rt = m_valid && (hx || m_ins.ertn || tq.size() < TD || trace_ready);
        wen = rt && m_ins.gr_we && !hx;
        ex = rt && hx;
        er = rt && m_ins.ertn && !hx;
        al = (!m_valid || rt) && !ex && !er;
        wd = m_ins.csr_re ? csr_rvalue : m_ins.result;
        tv = tq.size() > 0;
        head = tv ? tq[0] : '0;
        check("WB_allowin", 64'(WB_allowin), 64'(al));
        check("rf_wen", 64'(rf_wen), 64'(wen));
        check("wb_ex", 64'(wb_ex), 64'(ex));
        check("ertn_flush", 64'(ertn_flush), 64'(er));
        check("csr_re", 64'(csr_re), 64'(m_valid && m_ins.csr_re));
        check("csr_num", 64'(csr_num), 64'(m_valid ? m_ins.csr_num : 14'h0));
        check("rf_waddr", 64'(rf_waddr), 64'(m_valid ? m_ins.rd : 5'h0));
        check("wb_pc", 64'(wb_pc), 64'(m_valid ? m_ins.pc : 32'h0));
        check("wb_vaddr", 64'(wb_vaddr), 64'(m_valid ? m_ins.vaddr : 32'h0));
        check("wb_ecode", 64'(wb_ecode), 64'(hx ? ecode_of(m_ins.exc) : 6'h0));
        check("wb_esubcode", 64'(wb_esubcode), 64'h0);
        if (m_valid) check("rf_wdata", 64'(rf_wdata), 64'(wd));
        check("trace_valid", 64'(trace_valid), 64'(tv));
        check("trace_pc", 64'(trace_pc), 64'(head.pc));
        check("trace_wen", 64'(trace_wen), 64'(head.wen));
        check("trace_rd", 64'(trace_rd), 64'(head.rd));
        check("trace_wdata", 64'(trace_wdata), 64'(head.data));
        if (!rst) begin
            if (tv && trace_ready) void'(tq.pop_front());
            if (rt && !hx && !m_ins.ertn) begin
                e.pc = m_ins.pc;
                e.wen = {4{wen}};
                e.rd = m_ins.rd;
                e.data = wd;
                tq.push_back(e);
            end
            if (ms_valid && al) begin
                m_valid = 1;
                m_ins = '{ms_pc, ms_gr_we, ms_rd, ms_result, ms_csr_re, ms_csr_num, ms_except, ms_ertn, ms_vaddr};
            end else if (rt) begin
                m_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ms_valid = 0; ms_pc = 0; ms_gr_we = 0; ms_rd = 0; ms_result = 0;
        ms_csr_re = 0; ms_csr_num = 0; ms_except = 0; ms_ertn = 0; ms_vaddr = 0;
    endtask

    task automatic set_ins(input logic [31:0] pc, input logic gr_we, input logic [4:0] rd,
                           input logic [31:0] result, input logic cre, input logic [13:0] cnum,
                           input logic [5:0] exc, input logic ertn, input logic [31:0] vaddr);
        ms_valid = 1; ms_pc = pc; ms_gr_we = gr_we; ms_rd = rd; ms_result = result;
        ms_csr_re = cre; ms_csr_num = cnum; ms_except = exc; ms_ertn = ertn; ms_vaddr = vaddr;
    endtask

    initial begin
        idle();
        trace_ready = 1;
        csr_rvalue = 32'hDEAD0001;
        tick(); tick();
        check("rst_allowin", 64'(WB_allowin), 64'h1);
        check("rst_trace_valid", 64'(trace_valid), 64'h0);
        check("rst_rf_wen", 64'(rf_wen), 64'h0);
        check("rst_csr_re", 64'(csr_re), 64'h0);
        rst = 0;
        // basic commit
        set_ins(32'h1c000000, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
        tick(); idle();
        check("basic_wen", 64'(rf_wen), 64'h1);
        check("basic_waddr", 64'(rf_waddr), 64'h5);
        check("basic_wdata", 64'(rf_wdata), 64'h1234);
        tick();
        check("basic_tvalid", 64'(trace_valid), 64'h1);
        check("basic_tpc", 64'(trace_pc), 64'h1c000000);
        check("basic_twen", 64'(trace_wen), 64'hF);
        tick();
        // CSR read
        set_ins(32'h1c000004, 1, 7, 32'h0, 1, 14'h5, 0, 0, 0);
        tick(); idle();
        check("csr_re", 64'(csr_re), 64'h1);
        check("csr_num", 64'(csr_num), 64'h5);
        check("csr_wdata", 64'(rf_wdata), 64'hDEAD0001);
        tick(); tick();
        // exception priority, second instruction waits out the flush cycle
        set_ins(32'h1c000008, 1, 3, 32'h55, 0, 0, EX_INT | EX_SYS, 0, 0);
        tick();
        set_ins(32'h1c00000c, 1, 4, 32'h66, 0, 0, EX_ALE, 0, 32'h3);
        check("prio_ex", 64'(wb_ex), 64'h1);
        check("prio_ecode_int", 64'(wb_ecode), 64'h00);
        check("prio_rf_wen", 64'(rf_wen), 64'h0);
        check("prio_allowin", 64'(WB_allowin), 64'h0);
        check("prio_no_trace", 64'(trace_valid), 64'h0);
        tick();
        check("prio_pulse", 64'(wb_ex), 64'h0);
        tick(); idle();
        check("ale_ex", 64'(wb_ex), 64'h1);
        check("ale_ecode", 64'(wb_ecode), 64'h09);
        check("ale_vaddr", 64'(wb_vaddr), 64'h3);
        check("ale_allowin", 64'(WB_allowin), 64'h0);
        tick(); tick();
        // back-pressure: fill FIFO, fifth instruction stalls
        trace_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_ins(32'h1c000100 + 32'(4 * i), 1, 5'(10 + i), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("bp_allowin", 64'(WB_allowin), 64'h0);
        check("bp_rf_wen", 64'(rf_wen), 64'h0);
        check("bp_head", 64'(trace_pc), 64'h1c000100);
        check("bp_wb_pc", 64'(wb_pc), 64'h1c000110);
        tick();
        check("bp_hold", 64'(WB_allowin), 64'h0);
        trace_ready = 1;
        #1;
        check("bp_commit", 64'(rf_wen), 64'h1);
        tick();
        trace_ready = 0;
        check("bp_new_head", 64'(trace_pc), 64'h1c000104);
        check("bp_new_data", 64'(trace_wdata), 64'h101);
        // exception and ertn while FIFO full
        set_ins(32'h1c000200, 1, 1, 32'h0, 0, 0, EX_BRK, 0, 0);
        tick(); idle();
        check("brk_ex", 64'(wb_ex), 64'h1);
        check("brk_ecode", 64'(wb_ecode), 64'h0C);
        check("brk_rf_wen", 64'(rf_wen), 64'h0);
        tick();
        check("brk_head", 64'(trace_pc), 64'h1c000104);
        set_ins(32'h1c000204, 0, 0, 32'h0, 0, 0, 0, 1, 0);
        tick(); idle();
        check("ertn_flush", 64'(ertn_flush), 64'h1);
        check("ertn_allowin", 64'(WB_allowin), 64'h0);
        tick();
        check("ertn_pulse", 64'(ertn_flush), 64'h0);
        // async reset with three entries queued and a commit in flight
        trace_ready = 1;
        tick();
        trace_ready = 0;
        set_ins(32'h1c000300, 1, 9, 32'h99, 0, 0, 0, 0, 0);
        tick(); idle();
        check("pre_rst_wen", 64'(rf_wen), 64'h1);
        check("pre_rst_head", 64'(trace_pc), 64'h1c000108);
        #2 rst = 1;
        #1;
        check("arst_tvalid", 64'(trace_valid), 64'h0);
        check("arst_wb_ex", 64'(wb_ex), 64'h0);
        check("arst_rf_wen", 64'(rf_wen), 64'h0);
        check("arst_allowin", 64'(WB_allowin), 64'h1);
        tick();
        rst = 0;
        check("post_rst_allowin", 64'(WB_allowin), 64'h1);
        check("post_rst_tvalid", 64'(trace_valid), 64'h0);
        trace_ready = 1;
        set_ins(32'h1c000400, 1, 2, 32'h77, 0, 0, 0, 0, 0);
        tick(); idle();
        check("post_rst_wen", 64'(rf_wen), 64'h1);
        check("post_rst_wdata", 64'(rf_wdata), 64'h77);
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
- Parametrised writeback/retire stage for the LoongArch pipeline. It holds the MEM->WB instruction in its own pipeline register, with a valid/allowin handshake.
- Selects CSR read data or the pipeline result, then commits to the register file.
- Prioritises exceptions into ecode/esubcode for the CSR unit.
- Pushes committed instructions into a TRACE_DEPTH-entry debug-trace FIFO. When the FIFO is full, retirement back-pressures the pipeline.

Parameters:
DATA_W, 32, register/CSR data and pc/vaddr width
RF_AW, 5, register-file address width
CSR_NUM_W, 14, CSR number width
TRACE_DEPTH, 4, trace FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ms_valid  in  1  MEM has an instruction for WB
WB_allowin  out  1  WB accepts ms_* this cycle
ms_pc  in  DATA_W  instruction pc
ms_gr_we  in  1  instruction writes GPR
ms_rd  in  RF_AW  destination register
ms_result  in  DATA_W  ALU/load result
ms_csr_re  in  1  result comes from CSR read
ms_csr_num  in  CSR_NUM_W  CSR number
ms_except  in  6  {int, adef, ine, sys, brk, ale}
ms_ertn  in  1  ertn instruction
ms_vaddr  in  DATA_W  faulting address (adef/ale)
csr_re  out  1  CSR read enable
csr_num  out  CSR_NUM_W  CSR number
csr_rvalue  in  DATA_W  CSR read data (combinational)
rf_wen  out  1  GPR write enable
rf_waddr  out  RF_AW  GPR write address
rf_wdata  out  DATA_W  GPR write data
wb_ex  out  1  exception commit pulse
ertn_flush  out  1  ertn commit pulse
wb_ecode  out  6  exception code
wb_esubcode  out  9  exception subcode
wb_pc  out  DATA_W  pc of WB instruction
wb_vaddr  out  DATA_W  bad vaddr
trace_valid  out  1  trace FIFO non-empty
trace_ready  in  1  consumer pops head
trace_pc  out  DATA_W  head pc
trace_wen  out  4  head byte-enables ({4{wen}})
trace_rd  out  RF_AW  head register
trace_wdata  out  DATA_W  head data

Behaviour:
- Reset (async): wb_valid=0, FIFO empty (rd/wr pointers and count = 0). All outputs then read 0: ecode, esubcode, rf_*, wb_ex, ertn_flush, csr_re, trace_*. WB_allowin=1.
- Payload outputs (wb_pc, rf_waddr, csr_num, wb_vaddr) come from the pipeline register but are gated to 0 when wb_valid=0.
- has_ex = wb_valid & |except_r.
- full = (count==TRACE_DEPTH). A pop frees a slot in the same cycle.
- retire = wb_valid & (has_ex | ertn_r | ~full | trace_ready).
- Excepting and ertn instructions retire unconditionally and are not traced.
- WB_allowin = (~wb_valid | retire) & ~wb_ex & ~ertn_flush. Capture happens when ms_valid & WB_allowin. An incoming instruction in a flush cycle is dropped.
- On retire without capture, wb_valid clears next cycle. Latency: capture at edge N, commit in cycle N+1 at the earliest.
- rf_wdata = csr_re ? csr_rvalue : result_r.
- rf_wen = retire & gr_we_r & ~has_ex.
- csr_re = wb_valid & csr_re_r.
- wb_ex = retire & has_ex.
- ertn_flush = retire & ertn_r & ~has_ex. Both are single-cycle pulses.
- ecode priority (highest first), when has_ex=1:
  - int -> 0x00
  - adef -> 0x08
  - ine -> 0x0D
  - sys -> 0x0B
  - brk -> 0x0C
  - ale -> 0x09
  - otherwise 0.
- esubcode is always 0. wb_vaddr is the registered ms_vaddr.
- Trace push = retire & ~has_ex & ~ertn_r. The pushed entry is {pc, {4{rf_wen}}, rd, rf_wdata}. Non-GPR-writing instructions push with wen=0.
- Trace pop = trace_valid & trace_ready.
- Pointers wrap modulo TRACE_DEPTH.
- Simultaneous push+pop: count unchanged, valid in every occupancy state including full and empty.
- Push when empty: trace_valid rises the next cycle (no fall-through).
- Reset mid-operation drops both the held instruction and all FIFO contents immediately.

Test Plan:
- Basic commit: ms_valid=1, pc=0x1c000000, gr_we=1, rd=5, result=0x1234, trace_ready=1 -> next cycle rf_wen=1, waddr=5, wdata=0x1234. Cycle after: trace_valid=1, trace_pc=0x1c000000, trace_wen=0xF.
- CSR read: csr_re=1, csr_num=0x5, csr_rvalue=0xDEAD0001, result=0x0 -> rf_wdata=0xDEAD0001 and csr_re=1 during the commit cycle.
- Priority: except={int=1, sys=1} -> wb_ecode=0x00, wb_ex=1 for 1 cycle, rf_wen=0, no trace push. Then except={adef=0, ale=1}, vaddr=0x3 -> ecode=0x09, wb_vaddr=0x3. In both wb_ex cycles, WB_allowin=0.
- Back-pressure: trace_ready=0, 4 traced instructions retire -> FIFO full. A 5th instruction is held with WB_allowin=0 and rf_wen=0. Raising trace_ready for 1 cycle gives a pop and a 5th commit in that cycle; count stays 4.
- Exception while full: FIFO full, trace_ready=0, WB holds an instruction with brk=1 -> wb_ex=1 with ecode=0x0C immediately; FIFO count stays 4.
- Async reset: assert rst mid-stream with 3 entries queued -> trace_valid=0, wb_ex=0 and rf_wen=0 without waiting for a clock edge. After release, WB_allowin=1.
